// File: rtl/core_pkg.sv
// core_pkg: shared RV32I opcodes, opcode classes, decoded bundle and decode-stage states
package core_pkg;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    CL_LUI     = 4'd0,
    CL_AUIPC   = 4'd1,
    CL_JAL     = 4'd2,
    CL_JALR    = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_LOAD    = 4'd5,
    CL_STORE   = 4'd6,
    CL_OPIMM   = 4'd7,
    CL_OP      = 4'd8,
    CL_FENCE   = 4'd9,
    CL_SYSTEM  = 4'd10,
    CL_ILLEGAL = 4'd15
  } opclass_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [3:0]  opclass;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        illegal;
  } dec_t;
endpackage

// File: rtl/core_idecode_comb.sv
// core_idecode_comb: combinational RV32I word decoder; CORE_IDECODE_ILLEGAL_EN enables funct3/funct7 legality checks
module core_idecode_comb
  import core_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_b5_o,
  output logic [3:0]  opclass_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        alu_src_imm_o,
  output logic        illegal_o
);
  opclass_e cls_raw, cls;
  logic bad;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opc = inst_i[6:0];
  assign f3 = inst_i[14:12];
  always_comb
    cls_raw = opc == OP_LUI    ? CL_LUI    :
              opc == OP_AUIPC  ? CL_AUIPC  :
              opc == OP_JAL    ? CL_JAL    :
              opc == OP_JALR   ? CL_JALR   :
              opc == OP_BRANCH ? CL_BRANCH :
              opc == OP_LOAD   ? CL_LOAD   :
              opc == OP_STORE  ? CL_STORE  :
              opc == OP_OPIMM  ? CL_OPIMM  :
              opc == OP_OP     ? CL_OP     :
              opc == OP_FENCE  ? CL_FENCE  :
              opc == OP_SYSTEM ? CL_SYSTEM : CL_ILLEGAL;
`ifdef CORE_IDECODE_ILLEGAL_EN
  logic [6:0] f7;
  assign f7 = inst_i[31:25];
  always_comb
    bad = (cls_raw == CL_BRANCH && f3[2:1] == 2'b01)
       || (cls_raw == CL_LOAD && (f3 == 3'b011 || f3[2:1] == 2'b11))
       || (cls_raw == CL_STORE && f3 > 3'b010)
       || (cls_raw == CL_JALR && f3 != 3'b000)
       || (cls_raw == CL_OP && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
       || (cls_raw == CL_OPIMM && ((f3 == 3'b001 && f7 != 7'h00)
                                || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)));
  assign illegal_o = cls == CL_ILLEGAL;
`else
  assign bad = 1'b0;
  assign illegal_o = 1'b0;
`endif
  assign cls = bad ? CL_ILLEGAL : cls_raw;
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'h000};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  always_comb
    imm_o = cls inside {CL_JALR, CL_LOAD, CL_OPIMM, CL_FENCE, CL_SYSTEM} ? imm_i :
            cls == CL_STORE                                           ? imm_s :
            cls == CL_BRANCH                                          ? imm_b :
            cls inside {CL_LUI, CL_AUIPC}                             ? imm_u :
            cls == CL_JAL                                             ? imm_j : 32'h0;
  assign rs1_o = inst_i[19:15];
  assign rs2_o = inst_i[24:20];
  assign rd_o = inst_i[11:7];
  assign funct3_o = f3;
  assign funct7_b5_o = inst_i[30];
  assign opclass_o = cls;
  assign reg_write_o = (cls inside {CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_OPIMM, CL_OP})
                    && inst_i[11:7] != 5'd0;
  assign mem_read_o = cls == CL_LOAD;
  assign mem_write_o = cls == CL_STORE;
  assign branch_o = cls == CL_BRANCH;
  assign jump_o = cls inside {CL_JAL, CL_JALR};
  assign alu_src_imm_o = !(cls inside {CL_OP, CL_BRANCH, CL_ILLEGAL});
endmodule

// File: rtl/core_idecode.sv
// core_idecode: decode stage with output + skid buffer and registered ready; CORE_IDECODE_ILLEGAL_EN enables legality checks
module core_idecode
  import core_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_instruction_i,
  input  logic [31:0] if_pc_i,
  output logic        if_ready_o,
  input  logic        ex_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [4:0]  id_rs1_o,
  output logic [4:0]  id_rs2_o,
  output logic [4:0]  id_rd_o,
  output logic [31:0] id_imm_o,
  output logic [2:0]  id_funct3_o,
  output logic        id_funct7_b5_o,
  output logic [3:0]  id_opclass_o,
  output logic        id_reg_write_o,
  output logic        id_mem_read_o,
  output logic        id_mem_write_o,
  output logic        id_branch_o,
  output logic        id_jump_o,
  output logic        id_alu_src_imm_o,
  output logic        id_illegal_o
);
  state_e state_q, state_d;
  logic if_ready_q, valid_q, in_fire, out_fire, load_out, load_skid;
  logic [31:0] skid_inst_q, skid_pc_q, pc_q, inst_sel, pc_sel;
  dec_t dec_q, dec_d;
  assign in_fire = if_valid_i & if_ready_q;
  assign out_fire = valid_q & ex_ready_i;
  // the skid only ever feeds the decoder while it is the oldest held word
  assign inst_sel = state_q == ST_TWO ? skid_inst_q : if_instruction_i;
  assign pc_sel = state_q == ST_TWO ? skid_pc_q : if_pc_i;
  core_idecode_comb u_comb (
    .inst_i        (inst_sel),
    .rs1_o         (dec_d.rs1),
    .rs2_o         (dec_d.rs2),
    .rd_o          (dec_d.rd),
    .imm_o         (dec_d.imm),
    .funct3_o      (dec_d.funct3),
    .funct7_b5_o   (dec_d.funct7_b5),
    .opclass_o     (dec_d.opclass),
    .reg_write_o   (dec_d.reg_write),
    .mem_read_o    (dec_d.mem_read),
    .mem_write_o   (dec_d.mem_write),
    .branch_o      (dec_d.branch),
    .jump_o        (dec_d.jump),
    .alu_src_imm_o (dec_d.alu_src_imm),
    .illegal_o     (dec_d.illegal)
  );
  always_comb begin
    state_d = flush_i              ? ST_EMPTY :
              state_q == ST_EMPTY  ? (in_fire ? ST_ONE : ST_EMPTY) :
              state_q == ST_ONE    ? (in_fire && !out_fire ? ST_TWO :
                                      !in_fire && out_fire ? ST_EMPTY : ST_ONE) :
                                     (out_fire ? ST_ONE : ST_TWO);
    load_skid = !flush_i && state_q == ST_ONE && in_fire && !out_fire;
    load_out = !flush_i && (state_q == ST_TWO ? out_fire
                                              : in_fire && (state_q == ST_EMPTY || out_fire));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      if_ready_q <= 1'b1;
      valid_q <= 1'b0;
      pc_q <= PC_INIT;
      dec_q <= '0;
      skid_inst_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if_ready_q <= state_d != ST_TWO;
      valid_q <= state_d != ST_EMPTY;
      if (load_out) begin
        pc_q <= pc_sel;
        dec_q <= dec_d;
      end else if (state_d == ST_EMPTY) begin
        pc_q <= PC_INIT;
      end
      if (load_skid) begin
        skid_inst_q <= if_instruction_i;
        skid_pc_q <= if_pc_i;
      end
    end
  end
  assign if_ready_o = if_ready_q;
  assign id_valid_o = valid_q;
  assign id_pc_o = pc_q;
  assign id_rs1_o = dec_q.rs1;
  assign id_rs2_o = dec_q.rs2;
  assign id_rd_o = dec_q.rd;
  assign id_imm_o = dec_q.imm;
  assign id_funct3_o = dec_q.funct3;
  assign id_funct7_b5_o = dec_q.funct7_b5;
  assign id_opclass_o = dec_q.opclass;
  assign id_reg_write_o = dec_q.reg_write;
  assign id_mem_read_o = dec_q.mem_read;
  assign id_mem_write_o = dec_q.mem_write;
  assign id_branch_o = dec_q.branch;
  assign id_jump_o = dec_q.jump;
  assign id_alu_src_imm_o = dec_q.alu_src_imm;
  assign id_illegal_o = dec_q.illegal;
endmodule

// File: tb/tb_core_idecode.sv
// tb_core_idecode: vector table, handshake sequences and random traffic against a queue-based reference model
module tb_core_idecode;
  localparam logic [31:0] PC_INIT = 32'h0;
`ifdef CORE_IDECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, if_valid_i = 1'b0, ex_ready_i = 1'b0;
  logic [31:0] if_instruction_i = '0, if_pc_i = '0;
  logic if_ready_o, id_valid_o, id_funct7_b5_o, id_reg_write_o, id_mem_read_o, id_mem_write_o;
  logic id_branch_o, id_jump_o, id_alu_src_imm_o, id_illegal_o;
  logic [31:0] id_pc_o, id_imm_o;
  logic [4:0] id_rs1_o, id_rs2_o, id_rd_o;
  logic [2:0] id_funct3_o;
  logic [3:0] id_opclass_o;
  logic [61:0] act;
  logic [5:0] act_flags;
  int checks = 0, errors = 0;

  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  ent_t q[$];
  typedef struct {logic [31:0] inst; logic [31:0] imm; logic [3:0] cls; logic [4:0] rd; logic [5:0] flags; bit ill;} vec_t;
  vec_t vt[16];

  core_idecode #(.PC_INIT(PC_INIT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .if_valid_i(if_valid_i),
    .if_instruction_i(if_instruction_i), .if_pc_i(if_pc_i), .if_ready_o(if_ready_o),
    .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .id_rd_o(id_rd_o), .id_imm_o(id_imm_o),
    .id_funct3_o(id_funct3_o), .id_funct7_b5_o(id_funct7_b5_o), .id_opclass_o(id_opclass_o),
    .id_reg_write_o(id_reg_write_o), .id_mem_read_o(id_mem_read_o), .id_mem_write_o(id_mem_write_o),
    .id_branch_o(id_branch_o), .id_jump_o(id_jump_o), .id_alu_src_imm_o(id_alu_src_imm_o),
    .id_illegal_o(id_illegal_o)
  );

  always #5 clk = ~clk;

  assign act_flags = {id_reg_write_o, id_mem_read_o, id_mem_write_o, id_branch_o, id_jump_o, id_alu_src_imm_o};
  assign act = {id_imm_o, id_opclass_o, id_rd_o, id_rs1_o, id_rs2_o, id_funct3_o, id_funct7_b5_o,
                act_flags, id_illegal_o};

  // Reference decode: opcode table lookup, legality rules and immediates rebuilt by weighted sums
  function automatic logic [61:0] ref_dec(logic [31:0] w);
    int cls, immv;
    bit bad;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
    bit rw, mr, mw, br, j, ai, ill;
    f3 = w[14:12];
    f7 = w[31:25];
    bad = 1'b0;
    case (w[6:0])
      7'h37: cls = 0;  7'h17: cls = 1;  7'h6F: cls = 2;  7'h67: cls = 3;
      7'h63: cls = 4;  7'h03: cls = 5;  7'h23: cls = 6;  7'h13: cls = 7;
      7'h33: cls = 8;  7'h0F: cls = 9;  7'h73: cls = 10; default: cls = 15;
    endcase
    if (ILL_EN) begin
      case (cls)
        3: bad = f3 != 0;
        4: bad = f3 == 2 || f3 == 3;
        5: bad = f3 == 3 || f3 >= 6;
        6: bad = f3 > 2;
        7: bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
        8: bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        default: bad = 1'b0;
      endcase
      if (bad) cls = 15;
    end
    case (cls)
      0, 1: imm = w & 32'hFFFF_F000;
      2: begin
        immv = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        imm = 32'(immv);
      end
      3, 5, 7, 9, 10: imm = 32'($signed(w) >>> 20);
      4: begin
        immv = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm = 32'(immv);
      end
      6: imm = (32'($signed(w) >>> 20) & ~32'h1F) | 32'(w[11:7]);
      default: imm = 32'h0;
    endcase
    rw = (cls inside {0, 1, 2, 3, 5, 7, 8}) && w[11:7] != 0;
    mr = cls == 5;
    mw = cls == 6;
    br = cls == 4;
    j = cls == 2 || cls == 3;
    ai = cls <= 10 && cls != 8 && cls != 4;
    ill = ILL_EN && cls == 15;
    return {imm, 4'(cls), w[11:7], w[19:15], w[24:20], f3, w[30], rw, mr, mw, br, j, ai, ill};
  endfunction

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  task automatic model_check();
    chk("valid", 64'(id_valid_o), 64'(q.size() > 0));
    chk("if_ready", 64'(if_ready_o), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("pc", 64'(id_pc_o), 64'(q[0].pc));
      chk("bundle", 64'(act), 64'(ref_dec(q[0].inst)));
    end else begin
      chk("empty_pc", 64'(id_pc_o), 64'(PC_INIT));
    end
  endtask

  task automatic step();
    bit o, i;
    @(posedge clk);
    o = q.size() > 0 && ex_ready_i;
    i = if_valid_i && q.size() < 2;
    if (flush_i) q.delete();
    else begin
      if (o) void'(q.pop_front());
      if (i) q.push_back('{if_instruction_i, if_pc_i});
    end
    #1 model_check();
  endtask

  task automatic drive(bit v, logic [31:0] w, logic [31:0] pc, bit exr, bit fl);
    if_valid_i = v;
    if_instruction_i = w;
    if_pc_i = pc;
    ex_ready_i = exr;
    flush_i = fl;
  endtask

  initial begin
    logic [31:0] e_imm;
    logic [3:0] e_cls;
    logic [5:0] e_flags;
    bit e_ill, kill;
    logic [6:0] ops[12];
    logic [31:0] w;
    vt[0]  = '{32'h00500093, 32'h00000005, 4'd7,  5'd1,  6'b100001, 1'b0};
    vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 4'd4,  5'd29, 6'b000100, 1'b0};
    vt[2]  = '{32'h800000EF, 32'hFFF00000, 4'd2,  5'd1,  6'b100011, 1'b0};
    vt[3]  = '{32'h123452B7, 32'h12345000, 4'd0,  5'd5,  6'b100001, 1'b0};
    vt[4]  = '{32'h0000B003, 32'h00000000, 4'd5,  5'd0,  6'b010001, 1'b1};
    vt[5]  = '{32'h0020A423, 32'h00000008, 4'd6,  5'd8,  6'b001001, 1'b0};
    vt[6]  = '{32'h002081B3, 32'h00000000, 4'd8,  5'd3,  6'b100000, 1'b0};
    vt[7]  = '{32'h402081B3, 32'h00000000, 4'd8,  5'd3,  6'b100000, 1'b0};
    vt[8]  = '{32'h00000000, 32'h00000000, 4'd15, 5'd0,  6'b000000, 1'b1};
    vt[9]  = '{32'hFFFFF297, 32'hFFFFF000, 4'd1,  5'd5,  6'b100001, 1'b0};
    vt[10] = '{32'h000100E7, 32'h00000000, 4'd3,  5'd1,  6'b100011, 1'b0};
    vt[11] = '{32'hFFF00093, 32'hFFFFFFFF, 4'd7,  5'd1,  6'b100001, 1'b0};
    vt[12] = '{32'h022081B3, 32'h00000000, 4'd8,  5'd3,  6'b100000, 1'b1};
    vt[13] = '{32'h00000073, 32'h00000000, 4'd10, 5'd0,  6'b000001, 1'b0};
    vt[14] = '{32'h4010D093, 32'h00000401, 4'd7,  5'd1,  6'b100001, 1'b0};
    vt[15] = '{32'h40109093, 32'h00000401, 4'd7,  5'd1,  6'b100001, 1'b1};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};

    #12;
    chk("rst_valid", 64'(id_valid_o), 64'd0);
    chk("rst_ready", 64'(if_ready_o), 64'd1);
    chk("rst_pc", 64'(id_pc_o), 64'(PC_INIT));
    chk("rst_bundle", 64'(act), 64'd0);
    rst_ni = 1'b1;

    for (int k = 0; k < 16; k++) begin
      drive(1'b1, vt[k].inst, 32'(4 * k), 1'b1, 1'b0);
      step();
      kill = ILL_EN && vt[k].ill;
      e_imm = kill ? 32'h0 : vt[k].imm;
      e_cls = kill ? 4'd15 : vt[k].cls;
      e_flags = kill ? 6'b0 : vt[k].flags;
      e_ill = ILL_EN && (vt[k].ill || vt[k].cls == 4'd15);
      chk("vec_valid", 64'(id_valid_o), 64'd1);
      chk("vec_imm", 64'(id_imm_o), 64'(e_imm));
      chk("vec_class", 64'(id_opclass_o), 64'(e_cls));
      chk("vec_rd", 64'(id_rd_o), 64'(vt[k].rd));
      chk("vec_flags", 64'(act_flags), 64'(e_flags));
      chk("vec_illegal", 64'(id_illegal_o), 64'(e_ill));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h00100093 + 32'(k << 20), 32'(4 * k), 1'b1, 1'b0);
      step();
      chk("stream_valid", 64'(id_valid_o), 64'd1);
      chk("stream_pc", 64'(id_pc_o), 64'(4 * k));
      chk("stream_ready", 64'(if_ready_o), 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("stream_drain", 64'(id_valid_o), 64'd0);

    drive(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    step();
    chk("bp_first_pc", 64'(id_pc_o), 64'h100);
    chk("bp_first_ready", 64'(if_ready_o), 64'd1);
    drive(1'b1, 32'h00600113, 32'h104, 1'b0, 1'b0);
    step();
    chk("bp_hold_pc", 64'(id_pc_o), 64'h100);
    chk("bp_full_ready", 64'(if_ready_o), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("bp_still_pc", 64'(id_pc_o), 64'h100);
    chk("bp_still_imm", 64'(id_imm_o), 64'd5);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("bp_second_pc", 64'(id_pc_o), 64'h104);
    chk("bp_second_imm", 64'(id_imm_o), 64'd6);
    chk("bp_ready_back", 64'(if_ready_o), 64'd1);
    step();
    chk("bp_empty", 64'(id_valid_o), 64'd0);

    drive(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00600113, 32'h204, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00700193, 32'h208, 1'b0, 1'b1);
    step();
    chk("flush2_valid", 64'(id_valid_o), 64'd0);
    chk("flush2_ready", 64'(if_ready_o), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("flush2_gone", 64'(id_valid_o), 64'd0);
    drive(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00600113, 32'h304, 1'b1, 1'b1);
    step();
    chk("flush1_valid", 64'(id_valid_o), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("flush1_dropped", 64'(id_valid_o), 64'd0);

    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)] | (n % 7 == 0 ? 7'($urandom) : 7'h0);
      if ($urandom_range(0, 1) == 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      drive($urandom_range(0, 9) < 7, w, $urandom & ~32'h3, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 5);
      step();
      if (n == 200) begin
        drive(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", 64'(id_valid_o), 64'd0);
        chk("arst_ready", 64'(if_ready_o), 64'd1);
        chk("arst_pc", 64'(id_pc_o), 64'(PC_INIT));
        chk("arst_bundle", 64'(act), 64'd0);
        #1 rst_ni = 1'b1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
